ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues imem reads, registers the returned instruction into the
//  ifetch->decode pipeline register. Obeys ifetch_stall_v_i / ifetch_flush_v_i from the hazard unit and
//  supplies imem_read_v_o back to it. Sits between imem and decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  XLEN        32             address / instruction width
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     asynchronous, active-low reset
//  imem_read_v_o    out  1     imem read request valid (level, held until imem_resp_v_i)
//  imem_addr_o      out  XLEN  imem read address, word aligned
//  imem_resp_v_i    in   1     imem response valid (one cycle)
//  imem_data_i      in   XLEN  instruction returned with imem_resp_v_i
//  stall_v_i        in   1     hazard ifetch stall: hold PC and output register
//  flush_v_i        in   1     hazard ifetch flush: squash current fetch
//  redirect_v_i     in   1     branch/jump taken (asserted with flush_v_i)
//  redirect_pc_i    in   XLEN  redirect target
//  decode_v_o       out  1     fetch packet valid to decode
//  decode_pc_o      out  XLEN  PC of packet
//  decode_instr_o   out  XLEN  instruction of packet
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=IDLE, imem_read_v_o=0, imem_addr_o=RESET_PC, decode_v_o=0,
//   decode_pc_o=0, decode_instr_o=32'h0000_0013 (NOP).
//  FSM fetch_state_e: IDLE -> REQ (first cycle after reset release); REQ: imem_read_v_o=1, addr=pc_q;
//   on imem_resp_v_i & ~flush: capture packet, pc_q+=4, stay REQ (back-to-back, 1 fetch per resp).
//   REQ & flush & ~resp -> KILL (request outstanding, response must be dropped); KILL: imem_read_v_o
//   held 1 on old addr, on imem_resp_v_i discard data -> REQ at new pc_q.
//  Flush: pc_q<=redirect_pc_i when redirect_v_i, decode_v_o<=0 next cycle; flush dominates stall and
//   a same-cycle imem_resp_v_i (response discarded, state REQ, no KILL needed).
//  Stall: pc_q, decode_* held; a response arriving during stall is captured into a one-entry hold
//   register (hold_v) and no new request issued until stall drops; hold entry presented first.
//  decode_v_o=1 for exactly one non-stalled cycle per accepted instruction; otherwise 0 (bubble).
//  PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. redirect_pc_i[1:0] ignored (forced 0).
//  Reset asserted mid-request: everything returns to reset values immediately; late imem response
//   after reset release is ignored unless state is REQ and a request is outstanding.
// CONFIGURATION
//  IFETCH_PREFETCH_EN defined: 2-entry prefetch FIFO replaces hold register; fetch continues while
//   decode stalls until FIFO full; flush empties FIFO same cycle. Latency imem_resp->decode_v_o = 1.
//  Undefined: single hold register as above; max one instruction buffered during stall.
// STRUCTURE
//  rvga_types package: fetch_state_e {IDLE,REQ,KILL}, fetch_pkt_s {pc, instr}, NOP_INSTR constant.
//  Sub-module ifetch_fifo (DEPTH=2, fetch_pkt_s) instantiated only under IFETCH_PREFETCH_EN.
// TESTING
//  Reset release, imem responds 1 cycle later with 0x00000093 -> addr 0x0, decode_v_o=1 pc 0x0, next addr 0x4.
//  Zero-wait imem for 4 fetches -> decode PCs 0x0,0x4,0x8,0xC consecutive cycles, no bubbles.
//  flush+redirect to 0x100 while resp outstanding -> KILL, stale resp dropped, next decode pc 0x100.
//  flush same cycle as resp at pc 0x8 -> resp discarded, decode_v_o=0, next request addr = redirect_pc.
//  stall 3 cycles with resp arriving -> decode_* stable, instruction delivered first after stall drops.
//  pc_q=0xFFFF_FFFC fetch -> next imem_addr_o=0x0; assert rst_i low mid-REQ -> all outputs reset values.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states, the
// packet handed to decode, the NOP used as the idle instruction, and the
// prefetch buffer depth.
package rvga_types;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int unsigned PREFETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_s;

  // Instruction addresses are always word aligned; the two LSBs are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small packet FIFO used as the prefetch buffer between imem responses and
// the decode register. A synchronous clear empties it in the same cycle.
// full_nxt_o reports whether the FIFO will be full after this cycle's
// push/pop, so the fetch side can stop requesting in time.
module ifetch_fifo
  import rvga_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fetch_pkt_s din_i,
  output fetch_pkt_s dout_o,
  output logic       valid_o,
  output logic       full_nxt_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_pkt_s    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nxt = cnt_q;
    if (push_i && !pop_i) begin
      cnt_nxt = cnt_q + CW'(1);
    end else if (pop_i && !push_i) begin
      cnt_nxt = cnt_q - CW'(1);
    end
  end

  assign valid_o    = (cnt_q != '0);
  assign dout_o     = mem_q[rd_ptr_q];
  assign full_nxt_o = !clr_i && (cnt_nxt == CW'(DEPTH));

  // Pointer and count bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_nxt;
    end
  end

  // Packet storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage. Owns the PC, issues level-held imem read
// requests and registers each accepted instruction into the decode
// register. A flush squashes in-flight work; if a request is still
// outstanding the FSM parks in KILL until its response arrives and is
// dropped. During a stall one response is caught in a hold register.
//
// Build option: define IFETCH_PREFETCH_EN to replace the hold register with
// a 2-entry prefetch FIFO (ifetch_fifo), letting fetch run ahead of a
// stalled decode until the FIFO is full.
module ifetch
  import rvga_types::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_read_v_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_resp_v_i,
  input  logic [XLEN-1:0] imem_data_i,
  input  logic            stall_v_i,
  input  logic            flush_v_i,
  input  logic            redirect_v_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            decode_v_o,
  output logic [XLEN-1:0] decode_pc_o,
  output logic [XLEN-1:0] decode_instr_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] flush_pc;
  logic            resp_acc;
  fetch_pkt_s      resp_pkt;

  logic            buf_v;
  fetch_pkt_s      buf_pkt;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_clr;
  logic            buf_full_nxt;

  // In REQ the request address always equals pc_q, so either can be bumped.
  assign pc_inc   = pc_q + XLEN'(4);
  assign flush_pc = redirect_v_i ? word_align(redirect_pc_i) : pc_q;
  assign resp_acc = (state_q == REQ) && imem_read_v_o && imem_resp_v_i;
  assign resp_pkt = '{pc: imem_addr_o, instr: imem_data_i};

  // A response goes straight to decode unless decode is stalled or older
  // packets are already waiting in the buffer.
  assign buf_clr  = flush_v_i;
  assign buf_pop  = !flush_v_i && !stall_v_i && buf_v;
  assign buf_push = !flush_v_i && resp_acc && (stall_v_i || buf_v);

`ifdef IFETCH_PREFETCH_EN
  ifetch_fifo #(
    .DEPTH (PREFETCH_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (buf_clr),
    .push_i     (buf_push),
    .pop_i      (buf_pop),
    .din_i      (resp_pkt),
    .dout_o     (buf_pkt),
    .valid_o    (buf_v),
    .full_nxt_o (buf_full_nxt)
  );
`else
  logic       hold_v;
  fetch_pkt_s hold_pkt;

  // One-entry hold register for a response that lands while decode stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_v   <= 1'b0;
      hold_pkt <= '0;
    end else if (buf_clr) begin
      hold_v <= 1'b0;
    end else if (buf_push) begin
      hold_v   <= 1'b1;
      hold_pkt <= resp_pkt;
    end else if (buf_pop) begin
      hold_v <= 1'b0;
    end
  end

  assign buf_v        = hold_v;
  assign buf_pkt      = hold_pkt;
  assign buf_full_nxt = buf_push || (hold_v && !buf_pop);
`endif

  // Fetch FSM with registered imem request and decode outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      imem_read_v_o  <= 1'b0;
      imem_addr_o    <= RESET_PC;
      decode_v_o     <= 1'b0;
      decode_pc_o    <= '0;
      decode_instr_o <= NOP_INSTR;
    end else if (flush_v_i) begin
      decode_v_o <= 1'b0;
      pc_q       <= flush_pc;
      if (imem_read_v_o && !imem_resp_v_i) begin
        // Request still in flight on the old address: wait it out.
        state_q <= KILL;
      end else begin
        state_q       <= REQ;
        imem_read_v_o <= 1'b1;
        imem_addr_o   <= flush_pc;
      end
    end else begin
      if (!stall_v_i) begin
        if (buf_v) begin
          decode_v_o     <= 1'b1;
          decode_pc_o    <= buf_pkt.pc;
          decode_instr_o <= buf_pkt.instr;
        end else if (resp_acc) begin
          decode_v_o     <= 1'b1;
          decode_pc_o    <= resp_pkt.pc;
          decode_instr_o <= resp_pkt.instr;
        end else begin
          decode_v_o <= 1'b0;
        end
      end
      case (state_q)
        IDLE: begin
          state_q       <= REQ;
          imem_read_v_o <= 1'b1;
          imem_addr_o   <= pc_q;
        end
        KILL: begin
          // Stale response is dropped; the request stays up on the new PC.
          if (imem_resp_v_i) begin
            state_q     <= REQ;
            imem_addr_o <= pc_q;
          end
        end
        REQ: begin
          imem_read_v_o <= !buf_full_nxt;
          if (resp_acc) begin
            pc_q        <= pc_inc;
            imem_addr_o <= pc_inc;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a directed vector table walking through the main
// scenarios, a hand-written mid-request reset sequence, then randomized
// stall/flush/response traffic checked against a queue-based model.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          HOLD_CAP = 1;
  localparam int          N_VEC = 21;
  localparam int          N_RND = 3000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_read_v_o;
  logic [31:0] imem_addr_o;
  logic        imem_resp_v_i;
  logic [31:0] imem_data_i;
  logic        stall_v_i;
  logic        flush_v_i;
  logic        redirect_v_i;
  logic [31:0] redirect_pc_i;
  logic        decode_v_o;
  logic [31:0] decode_pc_o;
  logic [31:0] decode_instr_o;

  ifetch #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_read_v_o  (imem_read_v_o),
    .imem_addr_o    (imem_addr_o),
    .imem_resp_v_i  (imem_resp_v_i),
    .imem_data_i    (imem_data_i),
    .stall_v_i      (stall_v_i),
    .flush_v_i      (flush_v_i),
    .redirect_v_i   (redirect_v_i),
    .redirect_pc_i  (redirect_pc_i),
    .decode_v_o     (decode_v_o),
    .decode_pc_o    (decode_pc_o),
    .decode_instr_o (decode_instr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] data;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_s;

  vec_s vt [N_VEC];

  // Reference model state: next fetch PC, address of the live request,
  // whether a request is up, whether its response is to be dropped, and
  // the packets buffered for a stalled decode.
  logic [31:0] m_pc, m_addr, m_dpc, m_di;
  logic        m_req, m_drop, m_started, m_dv;
  logic [63:0] m_q[$];

  function automatic vec_s mk(input logic st, input logic fl, input logic [31:0] rpc,
                              input logic rs, input logic [31:0] dat,
                              input logic rv, input logic [31:0] addr, input logic dv,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_s v;
    v.stall = st; v.flush = fl; v.rpc = rpc; v.resp = rs; v.data = dat;
    v.e_rv = rv; v.e_addr = addr; v.e_dv = dv; v.e_pc = pc; v.e_instr = ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input logic rv, input logic [31:0] addr,
                         input logic dv, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".read_v"}, 32'(imem_read_v_o), 32'(rv));
    chk({tag, ".addr"}, imem_addr_o, addr);
    chk({tag, ".dec_v"}, 32'(decode_v_o), 32'(dv));
    if (dv) begin
      chk({tag, ".dec_pc"}, decode_pc_o, pc);
      chk({tag, ".dec_instr"}, decode_instr_o, ins);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    cmp_out(tag, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    chk({tag, ".dec_pc"}, decode_pc_o, 32'h0);
    chk({tag, ".dec_instr"}, decode_instr_o, NOP);
  endtask

  task automatic drive(input logic st, input logic fl, input logic [31:0] rpc,
                       input logic rs, input logic [31:0] dat);
    stall_v_i     = st;
    flush_v_i     = fl;
    redirect_v_i  = fl;
    redirect_pc_i = rpc;
    imem_resp_v_i = rs;
    imem_data_i   = dat;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_drop = 1'b0; m_started = 1'b0;
    m_dv = 1'b0; m_dpc = 32'h0; m_di = NOP;
    m_q.delete();
  endtask

  // One clock of the model, from this cycle's inputs.
  task automatic model_step(input logic st, input logic fl, input logic [31:0] rpc,
                            input logic rs, input logic [31:0] dat);
    logic        acc;
    logic [63:0] pkt;
    if (fl) begin
      m_dv = 1'b0;
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (m_req && !rs) begin
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0; m_req = 1'b1; m_addr = m_pc;
      end
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1; m_req = 1'b1; m_addr = m_pc;
      if (!st) m_dv = 1'b0;
    end else if (m_drop) begin
      if (rs) begin m_drop = 1'b0; m_addr = m_pc; end
      if (!st) m_dv = 1'b0;
    end else begin
      acc = m_req && rs;
      pkt = {m_addr, dat};
      if (acc) begin m_pc = m_addr + 32'd4; m_addr = m_pc; end
      if (st) begin
        if (acc) m_q.push_back(pkt);
      end else if (m_q.size() > 0) begin
        {m_dpc, m_di} = m_q.pop_front();
        m_dv = 1'b1;
        if (acc) m_q.push_back(pkt);
      end else if (acc) begin
        {m_dpc, m_di} = pkt;
        m_dv = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      m_req = (m_q.size() < HOLD_CAP);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        st, fl, rs;
    logic [31:0] rpc, dat;

    //        stall flush rpc           resp data          rv  addr          dv  pc            instr
    vt[0]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0);
    vt[1]  = mk(0, 0, 32'h0,         1, 32'h0000_0093, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'h0000_0093);
    vt[2]  = mk(0, 0, 32'h0,         1, 32'h0000_00A1, 1, 32'h0000_0008, 1, 32'h0000_0004, 32'h0000_00A1);
    vt[3]  = mk(0, 0, 32'h0,         1, 32'h0000_00A2, 1, 32'h0000_000C, 1, 32'h0000_0008, 32'h0000_00A2);
    vt[4]  = mk(0, 0, 32'h0,         1, 32'h0000_00A3, 1, 32'h0000_0010, 1, 32'h0000_000C, 32'h0000_00A3);
    vt[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0);
    vt[6]  = mk(0, 1, 32'h0000_0100, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0);
    vt[7]  = mk(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0000_0100, 0, 32'h0,         32'h0);
    vt[8]  = mk(0, 0, 32'h0,         1, 32'h0000_00B0, 1, 32'h0000_0104, 1, 32'h0000_0100, 32'h0000_00B0);
    vt[9]  = mk(0, 0, 32'h0,         1, 32'h0000_00B1, 1, 32'h0000_0108, 1, 32'h0000_0104, 32'h0000_00B1);
    vt[10] = mk(0, 1, 32'h0000_0203, 1, 32'h0000_0BAD, 1, 32'h0000_0200, 0, 32'h0,         32'h0);
    vt[11] = mk(0, 0, 32'h0,         1, 32'h0000_00C0, 1, 32'h0000_0204, 1, 32'h0000_0200, 32'h0000_00C0);
    vt[12] = mk(1, 0, 32'h0,         1, 32'h0000_00C1, 0, 32'h0000_0208, 1, 32'h0000_0200, 32'h0000_00C0);
    vt[13] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0208, 1, 32'h0000_0200, 32'h0000_00C0);
    vt[14] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0208, 1, 32'h0000_0200, 32'h0000_00C0);
    vt[15] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0208, 1, 32'h0000_0204, 32'h0000_00C1);
    vt[16] = mk(0, 0, 32'h0,         1, 32'h0000_00C2, 1, 32'h0000_020C, 1, 32'h0000_0208, 32'h0000_00C2);
    vt[17] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'h0000_020C, 0, 32'h0,         32'h0);
    vt[18] = mk(0, 0, 32'h0,         1, 32'h1111_1111, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    vt[19] = mk(0, 0, 32'h0,         1, 32'h0000_00D0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_00D0);
    vt[20] = mk(0, 0, 32'h0,         1, 32'h0000_00D1, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'h0000_00D1);

    rst_i = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    check_reset_vals("reset");

    for (int i = 0; i < N_VEC; i++) begin
      drive(vt[i].stall, vt[i].flush, vt[i].rpc, vt[i].resp, vt[i].data);
      @(posedge clk_i);
      #1;
      cmp_out($sformatf("vec%0d", i), vt[i].e_rv, vt[i].e_addr, vt[i].e_dv,
              vt[i].e_pc, vt[i].e_instr);
    end

    // Reset dropped while a request is up: outputs return at once, and a
    // response held high across release is ignored in the IDLE cycle.
    drive(0, 0, 32'h0, 0, 32'h0);
    rst_i = 1'b0;
    #1;
    check_reset_vals("midreset");
    #1;
    drive(0, 0, 32'h0, 1, 32'h5555_5555);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmp_out("late_resp", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
    drive(0, 0, 32'h0, 1, 32'h0000_0093);
    @(posedge clk_i);
    #1;
    cmp_out("first_fetch", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_0093);

    // Randomized traffic against the model.
    drive(0, 0, 32'h0, 0, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
    for (int n = 0; n < N_RND; n++) begin
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 7);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_FFFF);
      rs  = m_req && ($urandom_range(0, 99) < 65);
      dat = $urandom;
      drive(st, fl, rpc, rs, dat);
      model_step(st, fl, rpc, rs, dat);
      @(posedge clk_i);
      #1;
      cmp_out("rnd", m_req, m_addr, m_dv, m_dpc, m_di);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
